// File: rtl/mini_alu_core_pkg.sv
// Shared definitions for the mini ALU core: opcodes and instruction field layout.
// Field positions are functions of ADDR_W so every user derives them the same way.
package mini_alu_core_pkg;

    localparam int OP_W       = 4;
    localparam int KEY_W      = 8;
    localparam int VGA_ADDR_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_STO  = 4'd1,
        OP_BLE  = 4'd2,
        OP_BGE  = 4'd3,
        OP_JMP  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_INC  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_CALL = 4'd10,
        OP_RET  = 4'd11,
        OP_VGA  = 4'd12,
        OP_KEY  = 4'd13
    } op_e;

    // Instruction = {op, dst, src1, src0}
    function automatic int insn_w(input int aw);
        return OP_W + 3 * aw;
    endfunction

    function automatic int src1_lsb(input int aw);
        return aw;
    endfunction

    function automatic int dst_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int op_lsb(input int aw);
        return 3 * aw;
    endfunction

endpackage

// File: rtl/mini_alu_core_if.sv
// Bus bundle between the core and its ROM, register file, video memory and keyboard.
// core = the sequencer side, sys = the surrounding memories/peripherals.
interface mini_alu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int IP_W   = 16,
    parameter int RGB_W  = 3
);
    localparam int INSN_W = 4 + 3 * ADDR_W;

    logic [IP_W-1:0]   oRomAddress;
    logic [INSN_W-1:0] iInstruction;
    logic [ADDR_W-1:0] oRfReadAddr0;
    logic [ADDR_W-1:0] oRfReadAddr1;
    logic [DATA_W-1:0] iRfData0;
    logic [DATA_W-1:0] iRfData1;
    logic              oRfWriteEnable;
    logic [ADDR_W-1:0] oRfWriteAddr;
    logic [DATA_W-1:0] oRfWriteData;
    logic              oVgaWriteEnable;
    logic [15:0]       oVgaWriteAddr;
    logic [RGB_W-1:0]  oVgaWriteData;
    logic              iKeyValid;
    logic [7:0]        iKey;
    logic              oKeyAck;
    logic              oStackErr;

    modport core (
        output oRomAddress, oRfReadAddr0, oRfReadAddr1, oRfWriteEnable, oRfWriteAddr,
               oRfWriteData, oVgaWriteEnable, oVgaWriteAddr, oVgaWriteData, oKeyAck, oStackErr,
        input  iInstruction, iRfData0, iRfData1, iKeyValid, iKey
    );

    modport sys (
        input  oRomAddress, oRfReadAddr0, oRfReadAddr1, oRfWriteEnable, oRfWriteAddr,
               oRfWriteData, oVgaWriteEnable, oVgaWriteAddr, oVgaWriteData, oKeyAck, oStackErr,
        output iInstruction, iRfData0, iRfData1, iKeyValid, iKey
    );

endinterface

// File: rtl/mini_alu_return_stack.sv
// LIFO of return addresses. Push when full / pop when empty are ignored here;
// the core reports those as stack errors.
module mini_alu_return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]          sp_q, sp_d, sp_m1;
    logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

    assign sp_m1 = sp_q - PTR_W'(1);
    assign full  = (sp_q == PTR_W'(DEPTH));
    assign empty = (sp_q == '0);
    assign top   = mem_q[sp_m1[IDX_W-1:0]];

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push && !full) begin
            mem_d[sp_q[IDX_W-1:0]] = push_data;
            sp_d = sp_q + PTR_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            mem_q <= '0;
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// Two-stage fetch/execute microsequencer: fetch addresses the ROM combinationally,
// execute decodes the registered instruction against registered RF read data.
module mini_alu_core #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int IP_W        = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RGB_W       = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    mini_alu_core_if.core bus
);
    import mini_alu_core_pkg::*;

    localparam int INSN_W = insn_w(ADDR_W);
    localparam int S1_LSB = src1_lsb(ADDR_W);
    localparam int DS_LSB = dst_lsb(ADDR_W);
    localparam int OP_LSB = op_lsb(ADDR_W);

    op_e               op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d, src1_q, src1_d, src0_q, src0_d;
    logic [IP_W-1:0]   ip_q, ip_d, pc_q, pc_d;
    logic              fwd0_q, fwd0_d, fwd1_q, fwd1_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] f_src0, f_src1, f_dst;
    logic [DATA_W-1:0] d0, d1, wr_data;
    logic [IP_W-1:0]   target, rom_addr, ret_addr, stk_top;
    logic              stall, taken, push, pop, wr_en, vga_en, key_ack;
    logic              stk_full, stk_empty;

    assign f_src0   = bus.iInstruction[0 +: ADDR_W];
    assign f_src1   = bus.iInstruction[S1_LSB +: ADDR_W];
    assign f_dst    = bus.iInstruction[DS_LSB +: ADDR_W];
    assign ret_addr = pc_q + IP_W'(1);

    mini_alu_return_stack #(.DEPTH(STACK_DEPTH), .W(IP_W)) u_stack (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Execute-stage decode
    always_comb begin
        d0      = fwd0_q ? res_q : bus.iRfData0;
        d1      = fwd1_q ? res_q : bus.iRfData1;
        stall   = 1'b0;
        taken   = 1'b0;
        target  = IP_W'(dst_q);
        push    = 1'b0;
        pop     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        vga_en  = 1'b0;
        key_ack = 1'b0;
        case (op_q)
            OP_STO:  begin wr_en = 1'b1; wr_data = DATA_W'({src1_q, src0_q}); end
            OP_BLE:  taken = (d1 <= d0);
            OP_BGE:  taken = (d1 >= d0);
            OP_JMP:  taken = 1'b1;
            OP_ADD:  begin wr_en = 1'b1; wr_data = d1 + d0; end
            OP_SUB:  begin wr_en = 1'b1; wr_data = d1 - d0; end
            OP_INC:  begin wr_en = 1'b1; wr_data = d1 + DATA_W'(1); end
            OP_AND:  begin wr_en = 1'b1; wr_data = d1 & d0; end
            OP_OR:   begin wr_en = 1'b1; wr_data = d1 | d0; end
            OP_CALL: begin taken = 1'b1; push = !stk_full; end
            OP_RET:  begin
                taken  = 1'b1;
                pop    = !stk_empty;
                target = stk_empty ? '0 : stk_top;
            end
            OP_VGA:  vga_en = 1'b1;
            OP_KEY:  begin
                if (bus.iKeyValid) begin
                    wr_en   = 1'b1;
                    wr_data = DATA_W'(bus.iKey);
                    key_ack = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: ;
        endcase
        rom_addr = taken ? target : ip_q;
    end

    // Fetch: capture the addressed instruction unless execute is stalled on KEY
    always_comb begin
        ip_d   = ip_q;
        pc_d   = pc_q;
        op_d   = op_q;
        dst_d  = dst_q;
        src1_d = src1_q;
        src0_d = src0_q;
        fwd0_d = fwd0_q;
        fwd1_d = fwd1_q;
        if (!stall) begin
            ip_d   = rom_addr + IP_W'(1);
            pc_d   = rom_addr;
            op_d   = op_e'(bus.iInstruction[OP_LSB +: OP_W]);
            dst_d  = f_dst;
            src1_d = f_src1;
            src0_d = f_src0;
            // RF read of this cycle misses the write landing at the same edge
            fwd0_d = wr_en && (f_src0 == dst_q);
            fwd1_d = wr_en && (f_src1 == dst_q);
        end
        res_d = wr_en ? wr_data : res_q;
        err_d = err_q | ((op_q == OP_CALL) && stk_full) | ((op_q == OP_RET) && stk_empty);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ip_q   <= '0;
            pc_q   <= '0;
            op_q   <= OP_NOP;
            dst_q  <= '0;
            src1_q <= '0;
            src0_q <= '0;
            fwd0_q <= 1'b0;
            fwd1_q <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            ip_q   <= ip_d;
            pc_q   <= pc_d;
            op_q   <= op_d;
            dst_q  <= dst_d;
            src1_q <= src1_d;
            src0_q <= src0_d;
            fwd0_q <= fwd0_d;
            fwd1_q <= fwd1_d;
            res_q  <= res_d;
            err_q  <= err_d;
        end
    end

    assign bus.oRomAddress     = rom_addr;
    assign bus.oRfReadAddr0    = f_src0;
    assign bus.oRfReadAddr1    = f_src1;
    assign bus.oRfWriteEnable  = wr_en;
    assign bus.oRfWriteAddr    = dst_q;
    assign bus.oRfWriteData    = wr_data;
    assign bus.oVgaWriteEnable = vga_en;
    assign bus.oVgaWriteAddr   = {d1[7:0], d0[7:0]};
    assign bus.oVgaWriteData   = dst_q[RGB_W-1:0];
    assign bus.oKeyAck         = key_ack;
    assign bus.oStackErr       = err_q;

endmodule

// File: doc/mini_alu_core.md
Name: mini_alu_core

Overview:
- Parametrised successor of the MiniAlu execution core: a 2-stage (fetch/execute) microsequencer driving an external instruction ROM, dual-read register file, video memory write port and PS/2 key source.
- Adds a multi-level return stack in place of the single return buffer.
- Adds SUB/AND/OR, a KEY-valid stall handshake, and result forwarding.
- Sits between the ROM/RAM instances and the VGA/keyboard blocks at the top level.

Parameters:
- DATA_W, 16, register-file data width
- ADDR_W, 8, register address width; instruction = {op[3:0], dst[ADDR_W-1:0], src1, src0}, width 4+3*ADDR_W
- IP_W, 16, instruction pointer width
- STACK_DEPTH, 4, return-stack entries (power of 2, ≥2)
- RGB_W, 3, pixel colour width (taken from dst[RGB_W-1:0])

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- oRomAddress  out  IP_W  instruction fetch address (combinational)
- iInstruction  in  4+3*ADDR_W  ROM data for oRomAddress, same cycle
- oRfReadAddr0  out  ADDR_W  = iInstruction src0 field
- oRfReadAddr1  out  ADDR_W  = iInstruction src1 field
- iRfData0  in  DATA_W  registered read data of addr0, valid in execute cycle
- iRfData1  in  DATA_W  registered read data of addr1
- oRfWriteEnable  out  1  register write strobe
- oRfWriteAddr  out  ADDR_W  write address (dst)
- oRfWriteData  out  DATA_W  write data
- oVgaWriteEnable  out  1  video memory write strobe
- oVgaWriteAddr  out  16  {src1 data[7:0], src0 data[7:0]} (column, row)
- oVgaWriteData  out  RGB_W  pixel colour
- iKeyValid  in  1  key code available
- iKey  in  8  key scan code
- oKeyAck  out  1  one-cycle pulse when key consumed
- oStackErr  out  1  sticky: return-stack overflow or underflow

Behaviour:
- Reset (Reset=0, async):
  - IP=0; execute regs = NOP; stack pointer=0; oStackErr=0.
  - All strobes 0; oRomAddress=0.
- Fetch: instruction fields captured into execute regs each cycle unless stalled.
- Execute: combinational decode of the registered op.
  - Opcodes:
    - NOP=0: no effect.
    - STO=1: dst <= {src1,src0} immediate, zero-extended/truncated to DATA_W.
    - BLE=2: branch to dst if D1<=D0 (unsigned).
    - BGE=3: branch to dst if D1>=D0 (unsigned).
    - JMP=4: branch to dst unconditionally.
    - ADD=5: dst <= D1+D0, mod 2^DATA_W.
    - SUB=6: dst <= D1-D0, mod 2^DATA_W.
    - INC=7: dst <= D1+1.
    - AND=8: dst <= D1&D0.
    - OR=9: dst <= D1|D0.
    - CALL=10: push return address, branch to dst.
    - RET=11: pop, branch to popped value.
    - VGA=12: write pixel.
    - KEY=13: dst <= zero-extended iKey.
    - 14–15: behave as NOP.
- Branch: when taken, oRomAddress = target in the same cycle. No delay slot: the sequential instruction is never executed. IP <= target+1.
- Forwarding: if the execute-stage op writes register R, and the fetched instruction reads R in the same cycle, D0/D1 in the next cycle come from the registered result, not the RAM. Both ports forward independently.
- Return address is (address of CALL)+1, IP_W bits.
- CALL when stack full: branch still taken, push dropped, oStackErr<=1.
- RET when empty: branch to 0, oStackErr<=1.
- oStackErr clears only on reset.
- KEY with iKeyValid=0: stall.
  - IP, oRomAddress and execute regs hold.
  - No writes; oKeyAck=0.
- KEY with iKeyValid=1: write iKey, oKeyAck=1 for exactly that cycle, advance.
- Reset mid-stall: abandon; no ack issued.
- Only one of oRfWriteEnable / oVgaWriteEnable is high in any cycle.

Decomposition:
- Shared package (definitions include): opcode constants, field-position constants derived from ADDR_W.
- One sub-module: mini_alu_return_stack.
  - LIFO of STACK_DEPTH×IP_W with push/pop/full/empty.
  - Async active-low reset.
  - Simultaneous push+pop is illegal and never issued.

Test Plan:
- Reset: hold Reset=0 3 cycles, release → oRomAddress 0,1,2 on consecutive cycles; all strobes 0 during reset.
- Forwarding: STO r1,0x0005; ADD r2,r1,r1; SUB r3,r2,r1 back-to-back → writes r1=5, r2=10, r3=5. Same with 0x0000−0x0001 → r3=0xFFFF (wrap).
- Branch, no delay slot:
  - BGE with D1=7, D0=7 at addr 4, target 20 → oRomAddress=20 in execute cycle; instruction at 5 not executed.
  - BLE with D1=8, D0=7 → falls through to 5.
- Nested calls: CALL depth 4 then 4 RET → returns to the correct addresses in reverse order, oStackErr=0. 5th CALL → oStackErr=1, jump taken. RET on empty → fetch 0.
- KEY stall: KEY r4 with iKeyValid low 6 cycles → oRomAddress constant, no writes. iKeyValid=1, iKey=0x1C → r4=0x001C, oKeyAck high 1 cycle.
- VGA: D1=0x0012, D0=0x0034, dst=3'b101 → oVgaWriteAddr=0x1234, data=5, oVgaWriteEnable 1 cycle, oRfWriteEnable=0.
